// File: rtl/biquad_cascade_sequencer.sv
// Cascade of NUM_SECTIONS 3.24 biquads evaluated on one shared signed MAC.
// Each rising edge of lr_clk runs one pass through every section in order.
module biquad_cascade_sequencer #(
  parameter int NUM_SECTIONS = 4
) (
  input  logic               state_clk,
  input  logic               reset_n,
  input  logic               lr_clk,
  input  logic signed [15:0] audio_in,
  input  logic        [2:0]  scale,
  input  logic               clear_hist,
  input  logic               coeff_we,
  input  logic        [5:0]  coeff_addr,
  input  logic signed [26:0] coeff_data,
  output logic signed [15:0] audio_out,
  output logic               out_valid,
  output logic               busy,
  output logic               coeff_err,
  output logic               overrun
);

  localparam int NC = 5 * NUM_SECTIONS;
  localparam int AW = $clog2(NC);
  localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam logic [SW-1:0] LAST_SEC = SW'(NUM_SECTIONS - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, MAC, WB, OUT} state_t;

  state_t r_state, w_nextState;

  logic               r_lrD;
  logic [SW-1:0]      r_sec;
  logic [2:0]         r_step;
  logic signed [26:0] r_x;
  logic signed [26:0] r_acc;
  logic signed [26:0] r_coef [NC];
  logic signed [26:0] r_x1 [NUM_SECTIONS];
  logic signed [26:0] r_x2 [NUM_SECTIONS];
  logic signed [26:0] r_y1 [NUM_SECTIONS];
  logic signed [26:0] r_y2 [NUM_SECTIONS];

  logic               w_trigger;
  logic               w_busy;
  logic               w_addrOk;
  logic [AW-1:0]      w_coefIdx;
  logic signed [26:0] w_coef;
  logic signed [26:0] w_operand;
  logic               w_prodNeg;
  logic [25:0]        w_prodBits;
  logic signed [26:0] w_term;
  logic signed [26:0] w_y;

  assign w_trigger = lr_clk & ~r_lrD;
  assign w_busy    = (r_state == CAPTURE) || (r_state == MAC) || (r_state == WB);
  assign busy      = w_busy;
  assign w_addrOk  = coeff_addr < 6'(NC);
  assign w_coefIdx = AW'(r_sec) * AW'(5) + AW'(r_step);

  always_comb begin
    w_coef    = r_coef[w_coefIdx];
    w_operand = r_x;
    case (r_step)
      3'd1:    w_operand = r_x1[r_sec];
      3'd2:    w_operand = r_x2[r_sec];
      3'd3:    w_operand = r_y1[r_sec];
      3'd4:    w_operand = r_y2[r_sec];
      default: w_operand = r_x;
    endcase
  end

  // Product keeps its true sign bit on top of the 26 bits below the 3.24 point.
  assign w_prodNeg  = (w_coef[26] ^ w_operand[26]) && (w_coef != '0) && (w_operand != '0);
  assign w_prodBits = 26'((54'(w_coef) * 54'(w_operand)) >>> 24);
  assign w_term     = {w_prodNeg, w_prodBits};
  assign w_y        = r_acc <<< scale;

  always_ff @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_nextState = CAPTURE;
      CAPTURE: w_nextState = MAC;
      MAC:     if (r_step == 3'd4) w_nextState = WB;
      WB:      w_nextState = (r_sec == LAST_SEC) ? OUT : MAC;
      OUT:     w_nextState = w_trigger ? CAPTURE : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lrD     <= 1'b0;
      r_sec     <= '0;
      r_step    <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      coeff_err <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NC; i++) r_coef[i] <= '0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
    end else begin
      r_lrD     <= lr_clk;
      out_valid <= 1'b0;
      coeff_err <= 1'b0;
      if (w_trigger && w_busy) overrun <= 1'b1;
      if (coeff_we && w_addrOk) begin
        if (w_busy) coeff_err <= 1'b1;
        else        r_coef[coeff_addr[AW-1:0]] <= coeff_data;
      end
      // Clearing only happens outside a pass, so it never collides with WB.
      if (clear_hist && !w_busy) begin
        for (int s = 0; s < NUM_SECTIONS; s++) begin
          r_x1[s] <= '0;
          r_x2[s] <= '0;
          r_y1[s] <= '0;
          r_y2[s] <= '0;
        end
      end
      case (r_state)
        CAPTURE: begin
          r_x    <= {audio_in, 11'b0};
          r_sec  <= '0;
          r_step <= '0;
        end
        MAC: begin
          r_acc  <= (r_step == 3'd0) ? w_term : r_acc + w_term;
          r_step <= (r_step == 3'd4) ? 3'd0 : r_step + 3'd1;
        end
        WB: begin
          r_x2[r_sec] <= r_x1[r_sec];
          r_x1[r_sec] <= r_x;
          r_y2[r_sec] <= r_y1[r_sec];
          r_y1[r_sec] <= w_y;
          r_x         <= w_y;
          if (r_sec == LAST_SEC) begin
            audio_out <= w_y[26:11];
            out_valid <= 1'b1;
          end else begin
            r_sec <= r_sec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade_sequencer.sv
// Self-checking bench for biquad_cascade_sequencer: directed cases plus random
// passes, all compared against an arithmetic model of the cascade.
module tb_biquad_cascade_sequencer;

  localparam int N = 4;

  logic               stateClk = 1'b0;
  logic               resetN;
  logic               lrClk;
  logic signed [15:0] audioIn;
  logic        [2:0]  scaleIn;
  logic               clearHist;
  logic               coeffWe;
  logic        [5:0]  coeffAddr;
  logic signed [26:0] coeffData;
  logic signed [15:0] audioOut;
  logic               outValid;
  logic               busy;
  logic               coeffErr;
  logic               overrun;

  int checks = 0;
  int passes = 0;

  // Reference state: coefficients and per-section histories as plain integers.
  longint mCoef [5*N];
  longint mX1 [N];
  longint mX2 [N];
  longint mY1 [N];
  longint mY2 [N];

  int                 obsLatency;
  int                 obsValid;
  int                 obsBusy;
  int                 obsErr;
  logic signed [15:0] obsOut;
  longint             expOut;

  always #5 stateClk = ~stateClk;

  biquad_cascade_sequencer #(.NUM_SECTIONS(N)) dut (
    .state_clk (stateClk),
    .reset_n   (resetN),
    .lr_clk    (lrClk),
    .audio_in  (audioIn),
    .scale     (scaleIn),
    .clear_hist(clearHist),
    .coeff_we  (coeffWe),
    .coeff_addr(coeffAddr),
    .coeff_data(coeffData),
    .audio_out (audioOut),
    .out_valid (outValid),
    .busy      (busy),
    .coeff_err (coeffErr),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Reduce any integer to the signed 27-bit range, wrapping modulo 2^27.
  function automatic longint wrap27(input longint v);
    longint r;
    r = v & 134217727;
    if (r >= 67108864) r -= 134217728;
    return r;
  endfunction

  // 3.24 fractional multiply: bits 49..24 of the product under its sign bit.
  function automatic longint fracMul(input longint a, input longint b);
    longint p;
    longint t;
    p = a * b;
    t = (p >>> 24) & 67108863;
    if (p < 0) t -= 67108864;
    return t;
  endfunction

  function automatic longint modelPass(input longint sample, input int sc);
    longint x;
    longint acc;
    longint y;
    x = sample * 2048;
    for (int s = 0; s < N; s++) begin
      acc = wrap27(fracMul(mCoef[s*5], x) + fracMul(mCoef[s*5+1], mX1[s]) +
                   fracMul(mCoef[s*5+2], mX2[s]) + fracMul(mCoef[s*5+3], mY1[s]) +
                   fracMul(mCoef[s*5+4], mY2[s]));
      y = wrap27(acc * (longint'(1) << sc));
      mX2[s] = mX1[s];
      mX1[s] = x;
      mY2[s] = mY1[s];
      mY1[s] = y;
      x = y;
    end
    return x >>> 11;
  endfunction

  function automatic void modelClearHist();
    for (int s = 0; s < N; s++) begin
      mX1[s] = 0;
      mX2[s] = 0;
      mY1[s] = 0;
      mY2[s] = 0;
    end
  endfunction

  task automatic writeCoef(input int addr, input longint data);
    @(negedge stateClk);
    coeffWe   = 1'b1;
    coeffAddr = 6'(addr);
    coeffData = 27'(data);
    @(negedge stateClk);
    coeffWe = 1'b0;
    if (addr < 5*N) mCoef[addr] = wrap27(data);
  endtask

  task automatic loadSections(input longint b1);
    for (int i = 0; i < 5*N; i++) writeCoef(i, (i % 5 == 0) ? b1 : 0);
  endtask

  // One lr_clk pass; k counts state_clk edges from the one that sees the trigger.
  task automatic applyStimulus(input logic signed [15:0] sample, input bit clr,
                               input int ovrAt, input int wrAt, input int rstAt);
    @(negedge stateClk);
    audioIn    = sample;
    lrClk      = 1'b1;
    clearHist  = clr;
    obsLatency = 0;
    obsValid   = 0;
    obsBusy    = 0;
    obsErr     = 0;
    obsOut     = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge stateClk);
      @(negedge stateClk);
      clearHist = 1'b0;
      coeffWe   = 1'b0;
      if (busy) obsBusy++;
      if (coeffErr) obsErr++;
      if (outValid) begin
        obsValid++;
        if (obsLatency == 0) obsLatency = k;
        obsOut = audioOut;
      end
      if (k == 3) lrClk = 1'b0;
      if (ovrAt > 0 && k == ovrAt) lrClk = 1'b1;
      if (ovrAt > 0 && k == ovrAt + 2) lrClk = 1'b0;
      if (wrAt > 0 && k == wrAt) begin
        coeffWe   = 1'b1;
        coeffAddr = 6'd0;
        coeffData = 27'sd12345;
      end
      if (rstAt > 0 && k == rstAt) begin
        resetN = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_audio_out", audioOut, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_out_valid", outValid, 0);
        break;
      end
    end
  endtask

  // Runs a pass, advances the model, and compares output and timing.
  task automatic runChecked(input string tag, input logic signed [15:0] sample, input bit clr);
    applyStimulus(sample, clr, 0, 0, 0);
    if (clr) modelClearHist();
    expOut = modelPass(sample, int'(scaleIn));
    checkOutput({tag, "_out"}, obsOut, expOut);
    checkOutput({tag, "_latency"}, obsLatency, 26);
    checkOutput({tag, "_valid_count"}, obsValid, 1);
  endtask

  initial begin
    logic signed [15:0] impulse [4];
    logic signed [15:0] impulseExp [4];
    resetN    = 1'b0;
    lrClk     = 1'b0;
    audioIn   = '0;
    scaleIn   = '0;
    clearHist = 1'b0;
    coeffWe   = 1'b0;
    coeffAddr = '0;
    coeffData = '0;
    for (int i = 0; i < 5*N; i++) mCoef[i] = 0;
    modelClearHist();
    #22;
    checkOutput("reset_audio_out", audioOut, 0);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_coeff_err", coeffErr, 0);
    @(negedge stateClk);
    resetN = 1'b1;

    // Passthrough: unity b1 in every section.
    loadSections(27'sh1000000);
    runChecked("passthru", 16'sh1234, 1'b0);
    checkOutput("passthru_const", obsOut, 16'sh1234);
    checkOutput("passthru_busy_cycles", obsBusy, 25);

    // Recursive impulse: a2 = +0.5 on section 0, history cleared with the trigger.
    writeCoef(3, 27'sh0800000);
    impulse    = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000};
    impulseExp = '{16'sh4000, 16'sh2000, 16'sh1000, 16'sh0800};
    for (int f = 0; f < 4; f++) begin
      runChecked("impulse", impulse[f], f == 0);
      checkOutput("impulse_const", obsOut, impulseExp[f]);
    end

    // Scale: 0.25 per section undone by a left shift of 2.
    loadSections(27'sh0400000);
    scaleIn = 3'd2;
    runChecked("scale", 16'shC000, 1'b1);
    checkOutput("scale_const", obsOut, 16'shC000);

    // Overrun: second edge ten cycles into the pass.
    scaleIn = 3'd0;
    loadSections(27'sh1000000);
    applyStimulus(16'sh0ABC, 1'b0, 10, 0, 0);
    expOut = modelPass(16'sh0ABC, 0);
    checkOutput("overrun_out", obsOut, expOut);
    checkOutput("overrun_valid_count", obsValid, 1);
    checkOutput("overrun_flag", overrun, 1);
    runChecked("after_overrun", 16'sh0321, 1'b0);
    checkOutput("overrun_sticky", overrun, 1);

    // Write while busy is rejected; out-of-range write is silently ignored.
    applyStimulus(16'sh1111, 1'b0, 0, 8, 0);
    expOut = modelPass(16'sh1111, 0);
    checkOutput("busy_write_out", obsOut, expOut);
    checkOutput("busy_write_err_pulses", obsErr, 1);
    runChecked("after_busy_write", 16'sh2222, 1'b0);
    @(negedge stateClk);
    coeffWe   = 1'b1;
    coeffAddr = 6'd20;
    coeffData = 27'sh0400000;
    @(negedge stateClk);
    coeffWe = 1'b0;
    checkOutput("addr20_no_err", coeffErr, 0);
    runChecked("after_addr20", 16'sh3333, 1'b0);

    // Random coefficients within +/-0.5, random samples, scale and clears.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 5*N; i++)
        writeCoef(i, longint'($urandom_range(0, 16777215)) - 8388608);
      scaleIn = 3'($urandom_range(0, 1));
      for (int f = 0; f < 2; f++)
        runChecked("random", 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a pass, then a clean passthrough.
    applyStimulus(16'sh5555, 1'b0, 0, 0, 12);
    @(negedge stateClk);
    resetN = 1'b1;
    for (int i = 0; i < 5*N; i++) mCoef[i] = 0;
    modelClearHist();
    scaleIn = 3'd0;
    loadSections(27'sh1000000);
    runChecked("post_reset", 16'sh7E01, 1'b0);
    checkOutput("post_reset_const", obsOut, 16'sh7E01);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
